// File: rtl/iot_dfp.sv
// IoT data-processing block: assembles IN_W-bit beats into W-bit words and
// reduces each round of ROUND words through a selectable statistic.
module iot_dfp #(
    parameter int IN_W   = 8,
    parameter int NBEATS = 16,
    parameter int ROUND  = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_en,
    input  logic [IN_W-1:0]        iot_in,
    input  logic [3:0]             fn_sel,
    input  logic [IN_W*NBEATS-1:0] lo_bnd,
    input  logic [IN_W*NBEATS-1:0] hi_bnd,
    output logic                   busy,
    output logic                   valid,
    output logic [IN_W*NBEATS-1:0] iot_out
);
    localparam int W  = IN_W * NBEATS;
    localparam int LG = $clog2(ROUND);
    localparam int BW = $clog2(NBEATS);
    localparam int SW = W + LG;

    typedef enum logic [3:0] {
        FN_MAX     = 4'd1,
        FN_MIN     = 4'd2,
        FN_TOP2MAX = 4'd3,
        FN_LAST2MIN = 4'd4,
        FN_AVG     = 4'd5,
        FN_EXTRACT = 4'd6,
        FN_EXCLUDE = 4'd7,
        FN_PEAKMAX = 4'd8,
        FN_PEAKMIN = 4'd9
    } fn_e;

    logic [3:0]    fn_q;
    logic [BW-1:0] beat_q, beat_d;
    logic [LG-1:0] word_q, word_d;
    logic [W-1:0]  buf_q, buf_d;
    logic [W-1:0]  max_q, max_d, smax_q, smax_d, min_q, min_d, smin_q, smin_d;
    logic [SW-1:0] sum_q, sum_d;
    logic [W-1:0]  pmax_q, pmax_d, pmin_q, pmin_d;
    logic          pend_q, pend_d;
    logic [W-1:0]  pval_q, pval_d;
    logic          valid_q, valid_d, busy_q, busy_d;
    logic [W-1:0]  out_q, out_d;

    logic          accept, done, rnd_end;
    logic [W-1:0]  cur_word, max_n, smax_n, min_n, smin_n;
    logic [SW-1:0] sum_n;

    // The shifted buffer doubles as the completed word on the final beat.
    assign accept   = in_en && !busy_q;
    assign cur_word = {iot_in, buf_q[W-1:IN_W]};
    assign done     = accept && (beat_q == BW'(NBEATS - 1));
    assign rnd_end  = done && (word_q == LG'(ROUND - 1));

    always_comb begin : acc_update
        // NOTE: every variable gets a default first so no path can infer a latch.
        max_n  = max_q;
        smax_n = smax_q;
        min_n  = min_q;
        smin_n = smin_q;
        if (cur_word > max_q) begin
            smax_n = max_q;
            max_n  = cur_word;
        end else if (cur_word > smax_q) begin
            smax_n = cur_word;
        end
        if (cur_word < min_q) begin
            smin_n = min_q;
            min_n  = cur_word;
        end else if (cur_word < smin_q) begin
            smin_n = cur_word;
        end
        sum_n = sum_q + SW'(cur_word);
    end

    always_comb begin : next_state
        beat_d  = beat_q;
        word_d  = word_q;
        buf_d   = buf_q;
        max_d   = max_q;
        smax_d  = smax_q;
        min_d   = min_q;
        smin_d  = smin_q;
        sum_d   = sum_q;
        pmax_d  = pmax_q;
        pmin_d  = pmin_q;
        pend_d  = 1'b0;
        pval_d  = pval_q;
        valid_d = 1'b0;
        busy_d  = 1'b0;
        out_d   = '0;
        if (fn_sel != fn_q) begin
            beat_d = '0;
            word_d = '0;
            max_d  = '0;
            smax_d = '0;
            min_d  = '1;
            smin_d = '1;
            sum_d  = '0;
            pmax_d = '0;
            pmin_d = '1;
        end else begin
            if (pend_q) begin
                valid_d = 1'b1;
                busy_d  = 1'b1;
                out_d   = pval_q;
            end
            if (accept) begin
                buf_d  = cur_word;
                beat_d = done ? '0 : beat_q + 1'b1;
            end
            if (done) begin
                word_d = rnd_end ? '0 : word_q + 1'b1;
                if (rnd_end) begin
                    max_d  = '0;
                    smax_d = '0;
                    min_d  = '1;
                    smin_d = '1;
                    sum_d  = '0;
                end else begin
                    max_d  = max_n;
                    smax_d = smax_n;
                    min_d  = min_n;
                    smin_d = smin_n;
                    sum_d  = sum_n;
                end
                case (fn_sel)
                    FN_MAX, FN_MIN, FN_AVG: if (rnd_end) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        out_d   = (fn_sel == FN_MAX) ? max_n :
                                  (fn_sel == FN_MIN) ? min_n : sum_n[SW-1:LG];
                    end
                    FN_TOP2MAX, FN_LAST2MIN: if (rnd_end) begin
                        valid_d = 1'b1;
                        busy_d  = 1'b1;
                        pend_d  = 1'b1;
                        out_d   = (fn_sel == FN_TOP2MAX) ? max_n : min_n;
                        pval_d  = (fn_sel == FN_TOP2MAX) ? smax_n : smin_n;
                    end
                    FN_EXTRACT: if (cur_word > lo_bnd && cur_word < hi_bnd) begin
                        valid_d = 1'b1;
                        out_d   = cur_word;
                    end
                    FN_EXCLUDE: if (cur_word < lo_bnd || cur_word > hi_bnd) begin
                        valid_d = 1'b1;
                        out_d   = cur_word;
                    end
                    FN_PEAKMAX: if (rnd_end) begin
                        busy_d = 1'b1;
                        if (max_n > pmax_q) begin
                            pmax_d  = max_n;
                            valid_d = 1'b1;
                            out_d   = max_n;
                        end
                    end
                    FN_PEAKMIN: if (rnd_end) begin
                        busy_d = 1'b1;
                        if (min_n < pmin_q) begin
                            pmin_d  = min_n;
                            valid_d = 1'b1;
                            out_d   = min_n;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fn_q    <= '0;
            beat_q  <= '0;
            word_q  <= '0;
            buf_q   <= '0;
            max_q   <= '0;
            smax_q  <= '0;
            min_q   <= '1;
            smin_q  <= '1;
            sum_q   <= '0;
            pmax_q  <= '0;
            pmin_q  <= '1;
            pend_q  <= 1'b0;
            pval_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            out_q   <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            fn_q    <= fn_sel;
            beat_q  <= beat_d;
            word_q  <= word_d;
            buf_q   <= buf_d;
            max_q   <= max_d;
            smax_q  <= smax_d;
            min_q   <= min_d;
            smin_q  <= smin_d;
            sum_q   <= sum_d;
            pmax_q  <= pmax_d;
            pmin_q  <= pmin_d;
            pend_q  <= pend_d;
            pval_q  <= pval_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            out_q   <= out_d;
        end
    end

    assign busy    = busy_q;
    assign valid   = valid_q;
    assign iot_out = out_q;

endmodule

// File: tb/tb_iot_dfp.sv
// Self-checking bench for iot_dfp: directed scenarios plus randomized rounds
// compared against a sort/sum based model of each statistic.
module tb_iot_dfp;
    localparam int IN_W = 8, NBEATS = 16, ROUND = 8, W = IN_W * NBEATS;
    typedef logic [W-1:0] word_t;
    typedef word_t wq_t[$];

    logic clk = 1'b0, rst = 1'b0, in_en = 1'b0;
    logic [IN_W-1:0] iot_in = '0;
    logic [3:0] fn_sel = '0;
    word_t lo_bnd = '0, hi_bnd = '0;
    logic busy, valid;
    word_t iot_out;

    int checks = 0, errors = 0, cyc = 0;
    int em_cyc[$];
    word_t em_val[$];
    logic busy_at[int];
    int e_q[$];
    int exp_cyc[$];
    word_t exp_val[$];
    word_t pk_max, pk_min;

    iot_dfp #(.IN_W(IN_W), .NBEATS(NBEATS), .ROUND(ROUND)) dut (
        .clk(clk), .rst(rst), .in_en(in_en), .iot_in(iot_in), .fn_sel(fn_sel),
        .lo_bnd(lo_bnd), .hi_bnd(hi_bnd), .busy(busy), .valid(valid), .iot_out(iot_out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor: logs every emitted result and polices idle zeros.
    always @(negedge clk) begin
        busy_at[cyc] = busy;
        if (valid === 1'b1) begin
            em_cyc.push_back(cyc);
            em_val.push_back(iot_out);
        end else begin
            checks++;
            if (iot_out !== '0) begin
                errors++;
                $display("FAIL idle_zero: cycle %0d iot_out=%h required 0", cyc, iot_out);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_fn(input logic [3:0] f);
        in_en  = 1'b0;
        fn_sel = f;
        idle(2);
    endtask

    task automatic clear_obs();
        em_cyc.delete();
        em_val.delete();
        exp_cyc.delete();
        exp_val.delete();
    endtask

    // Sends beats 0..nb-1 of w; holds each beat while busy, with random gaps.
    task automatic send_beats(input word_t w, input int nb);
        for (int k = 0; k < nb; k++) begin
            int tries;
            if ($urandom_range(0, 4) == 0) begin
                in_en = 1'b0;
                @(negedge clk);
            end
            in_en  = 1'b1;
            iot_in = w[k*IN_W +: IN_W];
            tries  = 0;
            while (busy === 1'b1 && tries < 16) begin
                @(negedge clk);
                tries++;
            end
            if (tries >= 16) begin
                checks++;
                errors++;
                $display("FAIL busy_timeout: beat %0d held %0d cycles, required release", k, tries);
            end
            @(negedge clk);
        end
    endtask

    task automatic run_round(input wq_t ws);
        e_q.delete();
        foreach (ws[i]) begin
            send_beats(ws[i], NBEATS);
            e_q.push_back(cyc);
        end
        in_en = 1'b0;
    endtask

    function automatic word_t rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic word_t small_word(input int hi);
        return word_t'($urandom_range(0, hi));
    endfunction

    // Expected emits for one round, from the statistic definitions.
    function automatic void model_round(input int fn, input wq_t ws);
        word_t s[$];
        logic [W+7:0] sm;
        int last;
        s = ws;
        s.sort();
        last = e_q[ROUND-1];
        sm = '0;
        case (fn)
            1: begin exp_cyc.push_back(last); exp_val.push_back(s[ROUND-1]); end
            2: begin exp_cyc.push_back(last); exp_val.push_back(s[0]); end
            3: begin
                exp_cyc.push_back(last);     exp_val.push_back(s[ROUND-1]);
                exp_cyc.push_back(last + 1); exp_val.push_back(s[ROUND-2]);
            end
            4: begin
                exp_cyc.push_back(last);     exp_val.push_back(s[0]);
                exp_cyc.push_back(last + 1); exp_val.push_back(s[1]);
            end
            5: begin
                foreach (ws[i]) sm += {8'd0, ws[i]};
                exp_cyc.push_back(last);
                exp_val.push_back(word_t'(sm / ROUND));
            end
            6: foreach (ws[i]) if (lo_bnd < ws[i] && ws[i] < hi_bnd) begin
                exp_cyc.push_back(e_q[i]); exp_val.push_back(ws[i]);
            end
            7: foreach (ws[i]) if (ws[i] < lo_bnd || ws[i] > hi_bnd) begin
                exp_cyc.push_back(e_q[i]); exp_val.push_back(ws[i]);
            end
            8: if (s[ROUND-1] > pk_max) begin
                pk_max = s[ROUND-1];
                exp_cyc.push_back(last); exp_val.push_back(pk_max);
            end
            9: if (s[0] < pk_min) begin
                pk_min = s[0];
                exp_cyc.push_back(last); exp_val.push_back(pk_min);
            end
            default: ;
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        idle(2);
        checks += 3;
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: got %b required 0", busy); end
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", valid); end
        if (iot_out !== '0) begin errors++; $display("FAIL reset_out: got %h required 0", iot_out); end
        rst = 1'b0;
        idle(2);
    endtask

    task automatic test_max_directed();
        wq_t ws;
        word_t req;
        int e;
        set_fn(4'd1);
        clear_obs();
        for (int k = 1; k <= ROUND; k++) ws.push_back(word_t'(k) << (W - 8));
        run_round(ws);
        e = e_q[ROUND-1];
        idle(3);
        req = word_t'(8) << (W - 8);
        checks += 2;
        if (em_cyc.size() != 1) begin errors++; $display("FAIL max_count: got %0d emits required 1", em_cyc.size()); end
        if (busy_at[e] !== 1'b1) begin errors++; $display("FAIL max_busy: got %b required 1", busy_at[e]); end
        if (em_cyc.size() >= 1) begin
            checks++;
            if (em_cyc[0] != e || em_val[0] !== req) begin
                errors++;
                $display("FAIL max_value: got %h at cycle %0d required %h at %0d", em_val[0], em_cyc[0], req, e);
            end
        end
    endtask

    task automatic test_top2_back_to_back();
        wq_t ws, ws2;
        int e;
        set_fn(4'd3);
        clear_obs();
        ws = '{word_t'(5), word_t'(9), word_t'(9), word_t'(1), word_t'(0), word_t'(0), word_t'(0), word_t'(0)};
        run_round(ws);
        e = e_q[ROUND-1];
        for (int i = 0; i < ROUND; i++) ws2.push_back(rnd_word());
        run_round(ws2);
        model_round(3, ws2);
        idle(3);
        checks += 3;
        if (em_cyc.size() != 4) begin errors++; $display("FAIL top2_count: got %0d emits required 4", em_cyc.size()); end
        if (busy_at[e] !== 1'b1) begin errors++; $display("FAIL top2_busy1: got %b required 1", busy_at[e]); end
        if (busy_at[e+1] !== 1'b1) begin errors++; $display("FAIL top2_busy2: got %b required 1", busy_at[e+1]); end
        for (int j = 0; j < 2 && j < em_cyc.size(); j++) begin
            checks++;
            if (em_cyc[j] != e + j || em_val[j] !== word_t'(9)) begin
                errors++;
                $display("FAIL top2_value%0d: got %h at %0d required 9 at %0d", j, em_val[j], em_cyc[j], e + j);
            end
        end
        for (int j = 0; j < 2 && j + 2 < em_cyc.size(); j++) begin
            checks++;
            if (em_cyc[j+2] != exp_cyc[j] || em_val[j+2] !== exp_val[j]) begin
                errors++;
                $display("FAIL top2_held%0d: got %h at %0d required %h at %0d", j, em_val[j+2], em_cyc[j+2], exp_val[j], exp_cyc[j]);
            end
        end
    endtask

    task automatic test_avg_directed();
        wq_t ws;
        set_fn(4'd5);
        clear_obs();
        for (int k = 1; k <= ROUND; k++) ws.push_back(word_t'(k));
        run_round(ws);
        idle(3);
        checks++;
        if (em_cyc.size() != 1 || em_val[0] !== word_t'(4) || em_cyc[0] != e_q[ROUND-1]) begin
            errors++;
            $display("FAIL avg_value: got %0d emits first %h required one emit of 4", em_cyc.size(),
                     (em_val.size() > 0) ? em_val[0] : word_t'(0));
        end
    endtask

    task automatic test_extract_directed();
        wq_t ws;
        set_fn(4'd6);
        clear_obs();
        lo_bnd = word_t'(10);
        hi_bnd = word_t'(20);
        ws = '{word_t'(10), word_t'(11), word_t'(20), word_t'(19), word_t'(0), word_t'(30), word_t'(9), word_t'(21)};
        run_round(ws);
        idle(3);
        checks++;
        if (em_cyc.size() != 2) begin errors++; $display("FAIL extract_count: got %0d emits required 2", em_cyc.size()); end
        if (em_cyc.size() == 2) begin
            checks += 3;
            if (em_val[0] !== word_t'(11) || em_cyc[0] != e_q[1]) begin
                errors++; $display("FAIL extract_first: got %h at %0d required 11 at %0d", em_val[0], em_cyc[0], e_q[1]);
            end
            if (em_val[1] !== word_t'(19) || em_cyc[1] != e_q[3]) begin
                errors++; $display("FAIL extract_second: got %h at %0d required 19 at %0d", em_val[1], em_cyc[1], e_q[3]);
            end
            if (busy_at[e_q[1]] !== 1'b0) begin errors++; $display("FAIL extract_busy: got %b required 0", busy_at[e_q[1]]); end
        end
    endtask

    task automatic test_peak_directed();
        int maxima[3] = '{50, 40, 60};
        int ends[3];
        set_fn(4'd8);
        clear_obs();
        for (int r = 0; r < 3; r++) begin
            wq_t ws;
            int pos = $urandom_range(0, ROUND - 1);
            for (int i = 0; i < ROUND; i++)
                ws.push_back((i == pos) ? word_t'(maxima[r]) : small_word(maxima[r] - 1));
            run_round(ws);
            ends[r] = e_q[ROUND-1];
        end
        idle(3);
        checks += 2;
        if (em_cyc.size() != 2) begin errors++; $display("FAIL peak_count: got %0d emits required 2", em_cyc.size()); end
        if (busy_at[ends[1]] !== 1'b1) begin errors++; $display("FAIL peak_quiet_busy: got %b required 1", busy_at[ends[1]]); end
        if (em_cyc.size() == 2) begin
            checks++;
            if (em_val[0] !== word_t'(50) || em_cyc[0] != ends[0] || em_val[1] !== word_t'(60) || em_cyc[1] != ends[2]) begin
                errors++;
                $display("FAIL peak_values: got %0d@%0d %0d@%0d required 50@%0d 60@%0d",
                         em_val[0], em_cyc[0], em_val[1], em_cyc[1], ends[0], ends[2]);
            end
        end
    endtask

    task automatic test_functions_random();
        for (int fn = 1; fn <= 9; fn++) begin
            int lasts[$];
            logic exp_b;
            set_fn(4'(fn));
            clear_obs();
            pk_max = '0;
            pk_min = '1;
            lo_bnd = small_word(40);
            hi_bnd = small_word(40);
            exp_b  = !(fn == 6 || fn == 7);
            for (int r = 0; r < 3; r++) begin
                wq_t ws;
                for (int i = 0; i < ROUND; i++)
                    ws.push_back((fn == 6 || fn == 7) ? small_word(40) :
                                 ($urandom_range(0, 1) == 1) ? rnd_word() : small_word(1000));
                run_round(ws);
                model_round(fn, ws);
                lasts.push_back(e_q[ROUND-1]);
            end
            idle(3);
            checks++;
            if (em_cyc.size() != exp_cyc.size()) begin
                errors++;
                $display("FAIL fn%0d_count: got %0d emits required %0d", fn, em_cyc.size(), exp_cyc.size());
            end
            for (int j = 0; j < em_cyc.size() && j < exp_cyc.size(); j++) begin
                checks++;
                if (em_cyc[j] != exp_cyc[j] || em_val[j] !== exp_val[j]) begin
                    errors++;
                    $display("FAIL fn%0d_emit%0d: got %h at %0d required %h at %0d", fn, j, em_val[j], em_cyc[j], exp_val[j], exp_cyc[j]);
                end
            end
            foreach (lasts[r]) begin
                checks++;
                if (busy_at[lasts[r]] !== exp_b) begin
                    errors++;
                    $display("FAIL fn%0d_busy_r%0d: got %b required %b", fn, r, busy_at[lasts[r]], exp_b);
                end
            end
        end
    endtask

    task automatic test_rst_mid();
        wq_t ws;
        set_fn(4'd1);
        for (int i = 0; i < ROUND; i++) ws.push_back(rnd_word());
        run_round(ws);
        checks++;
        if (valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid: got %b required 1", valid); end
        #2 rst = 1'b1;
        #1;
        checks += 3;
        if (valid !== 1'b0)  begin errors++; $display("FAIL rst_async_valid: got %b required 0", valid); end
        if (busy !== 1'b0)   begin errors++; $display("FAIL rst_async_busy: got %b required 0", busy); end
        if (iot_out !== '0)  begin errors++; $display("FAIL rst_async_out: got %h required 0", iot_out); end
        @(negedge clk);
        rst = 1'b0;
        set_fn(4'd2);
        send_beats('0, NBEATS);
        send_beats('0, NBEATS);
        send_beats('0, 8);
        in_en = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        idle(3);
        clear_obs();
        ws.delete();
        for (int i = 0; i < ROUND; i++) ws.push_back(rnd_word() | (word_t'(1) << (W - 1)));
        run_round(ws);
        model_round(2, ws);
        idle(3);
        checks++;
        if (em_cyc.size() != 1 || em_val[0] !== exp_val[0] || em_cyc[0] != exp_cyc[0]) begin
            errors++;
            $display("FAIL rst_mid_min: got %0d emits first %h required one emit of %h", em_cyc.size(),
                     (em_val.size() > 0) ? em_val[0] : word_t'(0), exp_val[0]);
        end
    endtask

    task automatic test_fn_switch();
        wq_t ws;
        set_fn(4'd1);
        for (int i = 0; i < 3; i++) send_beats('0, NBEATS);
        send_beats('1, 5);
        set_fn(4'd2);
        clear_obs();
        for (int i = 0; i < ROUND; i++) ws.push_back(rnd_word() | (word_t'(1) << (W - 1)));
        run_round(ws);
        model_round(2, ws);
        idle(3);
        checks++;
        if (em_cyc.size() != 1 || em_val[0] !== exp_val[0] || em_cyc[0] != exp_cyc[0]) begin
            errors++;
            $display("FAIL switch_min: got %0d emits first %h required one emit of %h", em_cyc.size(),
                     (em_val.size() > 0) ? em_val[0] : word_t'(0), exp_val[0]);
        end
        // Peak must restart from zero after leaving and re-entering PEAKMAX.
        set_fn(4'd8);
        ws.delete();
        for (int i = 0; i < ROUND; i++) ws.push_back((i == 3) ? word_t'(100) : small_word(99));
        run_round(ws);
        set_fn(4'd0);
        set_fn(4'd8);
        clear_obs();
        ws.delete();
        for (int i = 0; i < ROUND; i++) ws.push_back((i == 5) ? word_t'(50) : small_word(49));
        run_round(ws);
        idle(3);
        checks++;
        if (em_cyc.size() != 1 || em_val[0] !== word_t'(50)) begin
            errors++;
            $display("FAIL switch_peak: got %0d emits first %h required one emit of 50", em_cyc.size(),
                     (em_val.size() > 0) ? em_val[0] : word_t'(0));
        end
    endtask

    task automatic test_idle_fn();
        logic [3:0] fns[2] = '{4'd0, 4'd12};
        foreach (fns[f]) begin
            wq_t ws;
            int start, nbusy;
            set_fn(fns[f]);
            clear_obs();
            start = cyc;
            for (int i = 0; i < ROUND; i++) ws.push_back(rnd_word());
            run_round(ws);
            idle(3);
            nbusy = 0;
            for (int c = start; c <= e_q[ROUND-1] + 2; c++) if (busy_at[c] === 1'b1) nbusy++;
            checks += 2;
            if (em_cyc.size() != 0) begin errors++; $display("FAIL idle_fn%0d_emits: got %0d required 0", fns[f], em_cyc.size()); end
            if (nbusy != 0) begin errors++; $display("FAIL idle_fn%0d_busy: got %0d busy cycles required 0", fns[f], nbusy); end
        end
    endtask

    initial begin
        test_reset();
        test_max_directed();
        test_top2_back_to_back();
        test_avg_directed();
        test_extract_directed();
        test_peak_directed();
        test_functions_random();
        test_rst_mid();
        test_fn_switch();
        test_idle_fn();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
